adc_capture_ctrl: RTL and testbench
===================================

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, even value >= 2: clk cycles per adc_clk period.
REQ-002 Parameter DEPTH, default 8, power of 2 >= 2: output FIFO depth in 16-bit words.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cap_start  input  1  single-cycle request to begin a capture.
REQ-006 cap_abort  input  1  single-cycle request to terminate a capture.
REQ-007 cap_len  input  16  number of 8-bit samples to capture; sampled when cap_start is accepted.
REQ-008 adc_data_in  input  8  parallel sample from the external ADC.
REQ-009 adc_clk  output  1  ADC sample clock, clk/CLK_DIV, 50% duty.
REQ-010 wr_data  output  16  packed sample word toward the SDRAM writer.
REQ-011 wr_valid  output  1  wr_data holds a valid word.
REQ-012 wr_ready  input  1  downstream accepts the word when wr_valid and wr_ready are both high.
REQ-013 cap_busy  output  1  high in states CAPT and FLUSH.
REQ-014 cap_done  output  1  single-cycle completion pulse.
REQ-015 ovf_cnt  output  8  count of words dropped because the FIFO was full, saturating at 255.

Function
REQ-016 Divider cnt SHALL count 0..CLK_DIV-1 and wrap continuously from reset, independent of state; adc_clk SHALL be 1 when cnt >= CLK_DIV/2, registered.
REQ-017 Strobe stb SHALL be high in the cycle where cnt == CLK_DIV-1; adc_data_in is sampled on that clk edge, coinciding with the adc_clk falling edge.
REQ-018 FSM states: IDLE, CAPT, FLUSH.
REQ-019 IDLE: cap_start with cap_len != 0 -> CAPT; load remaining = cap_len; clear ovf_cnt, pack state, and FIFO.
REQ-020 IDLE: cap_start with cap_len == 0 -> cap_done pulse on the next cycle; stay in IDLE; ovf_cnt cleared.
REQ-021 cap_start SHALL be ignored in CAPT and FLUSH.
REQ-022 CAPT: each stb captures one sample and decrements remaining; non-stb cycles do not capture.
REQ-023 Packing: the first sample of a pair goes to wr_data[7:0] and the second to [15:8]; the word is pushed on the edge that captures the second sample.
REQ-024 Odd cap_len: the final sample is pushed with [15:8] = 8'h00 on the edge that captures it.
REQ-025 Capturing the last sample (remaining 1 -> 0) SHALL move the FSM to FLUSH on the same edge.
REQ-026 FLUSH: when the FIFO is empty -> IDLE, with cap_done high for exactly that one cycle.
REQ-027 FIFO: first-word-fall-through; wr_valid = not empty; wr_data = head word; pop on wr_valid and wr_ready.
REQ-028 A pushed word SHALL be visible on wr_data/wr_valid in the cycle after the push edge.
REQ-029 Push while full SHALL succeed if a pop occurs in the same cycle; otherwise the word is dropped and ovf_cnt increments, saturating at 255.
REQ-030 Simultaneous push and pop with the FIFO not full: occupancy unchanged, order preserved.
REQ-031 Dropped words SHALL still count toward cap_len, so capture length is never extended.
REQ-032 wr_data and wr_valid SHALL hold stable while wr_valid is high and wr_ready is low.
REQ-033 cap_abort in CAPT or FLUSH -> IDLE on the next edge: FIFO and pack state cleared, no cap_done, ovf_cnt retained; cap_abort is ignored in IDLE.
REQ-034 cap_abort and cap_start in the same IDLE cycle: cap_start wins.

Reset
REQ-035 Asynchronous assertion: state = IDLE, cnt = 0, adc_clk = 0, FIFO empty (wr_valid = 0), wr_data = 16'h0000, cap_busy = 0, cap_done = 0, ovf_cnt = 0, remaining = 0.
REQ-036 Reset mid-capture SHALL discard all buffered data with no cap_done pulse; after deassertion the divider restarts from cnt = 0.

Verification
REQ-037 CLK_DIV=4, cap_len=4, samples 11,22,33,44, wr_ready=1 -> words 16'h2211 then 16'h4433, then cap_done pulse, ovf_cnt=0.
REQ-038 cap_len=3, samples A1,B2,C3 -> words 16'hB2A1 and 16'h00C3; cap_done after the last pop.
REQ-039 DEPTH=8, cap_len=20, wr_ready=0 throughout capture -> 8 words buffered, ovf_cnt=2; wr_ready=1 drains 8 words, then cap_done.
REQ-040 cap_len=0 -> no wr_valid; cap_done one cycle after cap_start; cap_busy stays 0.
REQ-041 cap_abort after 3 samples -> IDLE, wr_valid=0, no cap_done; a new cap_start=2 yields exactly one word.
REQ-042 rst_n pulsed low mid-CAPT with 2 words queued -> all outputs at reset values immediately; adc_clk restarts at 0.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: divides clk into an ADC sample clock, packs 8-bit
// samples into 16-bit words and buffers them in a small FWFT FIFO for the SDRAM writer.
module adc_capture_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_start,
  input  logic        cap_abort,
  input  logic [15:0] cap_len,
  input  logic [7:0]  adc_data_in,
  output logic        adc_clk,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        cap_busy,
  output logic        cap_done,
  output logic [7:0]  ovf_cnt
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CAPT  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // ---------------------------------------------------------------------------
  // Free-running divider; stb marks the edge where adc_clk falls.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          adc_clk_q;
  logic          stb;

  assign stb   = (cnt_q == CNT_MAX);
  assign cnt_d = stb ? '0 : cnt_q + CW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      adc_clk_q <= (cnt_d >= CNT_HALF);
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, fifo_empty;
  logic          push, push_ok, pop, drop, fifo_clr;
  logic [15:0]   push_word;

  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && wr_ready;
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  // ---------------------------------------------------------------------------
  // Capture FSM and sample packing
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  lo_q, lo_d;
  logic        have_lo_q, have_lo_d;
  logic        done_q, done_d;
  logic        ovf_clr;

  // NOTE: every combinational output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lo_d        = lo_q;
    have_lo_d   = have_lo_q;
    done_d      = 1'b0;
    push        = 1'b0;
    push_word   = 16'h0000;
    fifo_clr    = 1'b0;
    ovf_clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cap_start) begin
          ovf_clr = 1'b1;
          if (cap_len != 16'd0) begin
            state_d     = S_CAPT;
            remaining_d = cap_len;
            lo_d        = 8'h00;
            have_lo_d   = 1'b0;
            fifo_clr    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_CAPT: begin
        if (cap_abort) begin
          state_d     = S_IDLE;
          remaining_d = 16'd0;
          have_lo_d   = 1'b0;
          fifo_clr    = 1'b1;
        end else if (stb) begin
          remaining_d = remaining_q - 16'd1;
          if (have_lo_q) begin
            push      = 1'b1;
            push_word = {adc_data_in, lo_q};
            have_lo_d = 1'b0;
          end else if (remaining_q == 16'd1) begin
            // Odd length: the lone final sample goes out zero-padded.
            push      = 1'b1;
            push_word = {8'h00, adc_data_in};
          end else begin
            lo_d      = adc_data_in;
            have_lo_d = 1'b1;
          end
          if (remaining_q == 16'd1) state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (cap_abort) begin
          state_d   = S_IDLE;
          have_lo_d = 1'b0;
          fifo_clr  = 1'b1;
        end else if (fifo_empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= 16'd0;
      lo_q        <= 8'h00;
      have_lo_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lo_q        <= lo_d;
      have_lo_q   <= have_lo_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (fifo_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // count_q, and an empty FIFO forces wr_data to zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  logic [7:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 8'h00;
    end else if (ovf_clr) begin
      ovf_q <= 8'h00;
    end else if (drop && ovf_q != 8'hFF) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign adc_clk  = adc_clk_q;
  assign wr_valid = !fifo_empty;
  assign wr_data  = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign cap_busy = (state_q == S_CAPT) || (state_q == S_FLUSH);
  assign cap_done = done_q;
  assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: directed captures push expected words,
// a negedge monitor pops and compares every accepted word.
module tb_adc_capture_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        cap_start   = 1'b0;
  logic        cap_abort   = 1'b0;
  logic [15:0] cap_len     = 16'd0;
  logic [7:0]  adc_data_in = 8'h00;
  logic        wr_ready    = 1'b1;
  logic        adc_clk;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        cap_busy;
  logic        cap_done;
  logic [7:0]  ovf_cnt;

  adc_capture_ctrl #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_start   (cap_start),
    .cap_abort   (cap_abort),
    .cap_len     (cap_len),
    .adc_data_in (adc_data_in),
    .adc_clk     (adc_clk),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .cap_busy    (cap_busy),
    .cap_done    (cap_done),
    .ovf_cnt     (ovf_cnt)
  );

  always #10 clk = ~clk;

  int          n_cmp     = 0;
  int          n_err     = 0;
  int          done_seen = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  smp [32];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_abort = 1'b0;
  logic [15:0] prev_data  = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h at %0t", name, act, $time);
  endtask

  // Monitor: pops the scoreboard on every accepted word, checks hold-while-stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (prev_valid && !prev_ready && !prev_abort) begin
        check("hold_valid", 32'(wr_valid), 32'd1);
        check("hold_data", 32'(wr_data), 32'(prev_data));
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_word", 32'(wr_data));
        else                   check("word", 32'(wr_data), 32'(exp_q.pop_front()));
      end
      if (cap_done) begin
        done_seen++;
        check("done_after_drain", 32'(exp_q.size()), 32'd0);
      end
      prev_valid <= wr_valid;
      prev_ready <= wr_ready;
      prev_abort <= cap_abort;
      prev_data  <= wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_adc_fall();
    logic prev;
    prev = adc_clk;
    for (int k = 0; k < 4 * CLK_DIV; k++) begin
      tick();
      if (prev && !adc_clk) return;
      prev = adc_clk;
    end
    fail_now("adc_clk_fall_timeout", 32'(adc_clk));
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (cap_done) return;
    end
    fail_now("cap_done_timeout", 32'(cap_busy));
  endtask

  // Start a capture right after an adc_clk fall and present smp[] one per strobe;
  // returns just after the edge that captured sample n_cap-1.
  task automatic run_capture(input logic [15:0] len, input int n_cap);
    wait_adc_fall();
    cap_start   = 1'b1;
    cap_len     = len;
    adc_data_in = smp[0];
    tick();
    cap_start = 1'b0;
    for (int i = 1; i < n_cap; i++) begin
      wait_adc_fall();
      adc_data_in = smp[i];
    end
    wait_adc_fall();
  endtask

  task automatic check_adc_pattern(input string name, input int n);
    logic [0:7] pat;
    pat = 8'b0110_0110;
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, 32'(adc_clk), 32'(pat[i]));
    end
  endtask

  initial begin
    int d0;

    // Reset state
    repeat (3) tick();
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_data",  32'(wr_data),  32'd0);
    check("rst_cap_busy", 32'(cap_busy), 32'd0);
    check("rst_cap_done", 32'(cap_done), 32'd0);
    check("rst_ovf_cnt",  32'(ovf_cnt),  32'd0);
    check("rst_adc_clk",  32'(adc_clk),  32'd0);
    rst_n = 1'b1;
    check_adc_pattern("adc_clk_div", 8);

    // Even length, free-flowing sink
    wr_ready = 1'b1;
    smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33; smp[3] = 8'h44;
    exp_q.push_back(16'h2211);
    exp_q.push_back(16'h4433);
    d0 = done_seen;
    run_capture(16'd4, 4);
    check("len4_busy_flush", 32'(cap_busy), 32'd1);
    wait_done(40);
    check("len4_done_busy", 32'(cap_busy), 32'd0);
    tick();
    check("len4_done_width", 32'(cap_done), 32'd0);
    check("len4_done_count", 32'(done_seen - d0), 32'd1);
    check("len4_ovf", 32'(ovf_cnt), 32'd0);
    check("len4_empty", 32'(wr_valid), 32'd0);

    // Odd length: last sample zero-padded
    smp[0] = 8'hA1; smp[1] = 8'hB2; smp[2] = 8'hC3;
    exp_q.push_back(16'hB2A1);
    exp_q.push_back(16'h00C3);
    d0 = done_seen;
    run_capture(16'd3, 3);
    wait_done(40);
    tick();
    check("len3_done_count", 32'(done_seen - d0), 32'd1);
    check("len3_empty", 32'(wr_valid), 32'd0);

    // Stalled sink: 8 words buffered, 2 dropped
    wr_ready = 1'b0;
    for (int i = 0; i < 20; i++) smp[i] = 8'(i + 1);
    exp_q.push_back(16'h0201); exp_q.push_back(16'h0403);
    exp_q.push_back(16'h0605); exp_q.push_back(16'h0807);
    exp_q.push_back(16'h0A09); exp_q.push_back(16'h0C0B);
    exp_q.push_back(16'h0E0D); exp_q.push_back(16'h100F);
    d0 = done_seen;
    run_capture(16'd20, 20);
    check("ovf_after_fill", 32'(ovf_cnt), 32'd2);
    check("full_valid", 32'(wr_valid), 32'd1);
    check("full_head", 32'(wr_data), 32'h0201);
    check("full_busy", 32'(cap_busy), 32'd1);
    repeat (3) tick();
    check("stall_no_done", 32'(cap_done), 32'd0);
    check("stall_head", 32'(wr_data), 32'h0201);
    wr_ready = 1'b1;
    wait_done(60);
    tick();
    check("drain_done_count", 32'(done_seen - d0), 32'd1);
    check("ovf_retained", 32'(ovf_cnt), 32'd2);
    check("drain_empty", 32'(wr_valid), 32'd0);

    // Zero length: immediate done, ovf cleared, never busy
    d0 = done_seen;
    cap_start = 1'b1;
    cap_len   = 16'd0;
    tick();
    cap_start = 1'b0;
    check("len0_done", 32'(cap_done), 32'd1);
    check("len0_busy", 32'(cap_busy), 32'd0);
    check("len0_valid", 32'(wr_valid), 32'd0);
    check("len0_ovf_clr", 32'(ovf_cnt), 32'd0);
    tick();
    check("len0_done_width", 32'(cap_done), 32'd0);
    check("len0_busy2", 32'(cap_busy), 32'd0);
    check("len0_done_count", 32'(done_seen - d0), 32'd1);

    // Abort after 3 samples, then a fresh 2-sample capture
    wr_ready = 1'b0;
    smp[0] = 8'h51; smp[1] = 8'h52; smp[2] = 8'h53;
    run_capture(16'd8, 3);
    check("abort_pre_valid", 32'(wr_valid), 32'd1);
    d0 = done_seen;
    cap_abort = 1'b1;
    tick();
    cap_abort = 1'b0;
    check("abort_valid", 32'(wr_valid), 32'd0);
    check("abort_data", 32'(wr_data), 32'd0);
    check("abort_busy", 32'(cap_busy), 32'd0);
    repeat (8) tick();
    check("abort_no_done", 32'(done_seen - d0), 32'd0);
    wr_ready = 1'b1;
    smp[0] = 8'h61; smp[1] = 8'h62;
    exp_q.push_back(16'h6261);
    run_capture(16'd2, 2);
    wait_done(40);
    tick();
    check("restart_done_count", 32'(done_seen - d0), 32'd1);
    check("restart_words_left", 32'(exp_q.size()), 32'd0);
    check("restart_empty", 32'(wr_valid), 32'd0);

    // Reset mid-capture with 2 words queued
    wr_ready = 1'b0;
    smp[0] = 8'h71; smp[1] = 8'h72; smp[2] = 8'h73; smp[3] = 8'h74;
    run_capture(16'd8, 4);
    check("rst_pre_valid", 32'(wr_valid), 32'd1);
    d0 = done_seen;
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(wr_valid), 32'd0);
    check("mid_rst_data",  32'(wr_data),  32'd0);
    check("mid_rst_busy",  32'(cap_busy), 32'd0);
    check("mid_rst_done",  32'(cap_done), 32'd0);
    check("mid_rst_ovf",   32'(ovf_cnt),  32'd0);
    check("mid_rst_adc",   32'(adc_clk),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_adc_pattern("adc_clk_restart", 4);
    wr_ready = 1'b1;
    repeat (4) tick();
    check("post_rst_no_done", 32'(done_seen - d0), 32'd0);
    check("post_rst_empty", 32'(wr_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
